// File: rtl/instr_encoder.sv
// Program loader: encodes one symbolic MIPS instruction per valid/ready handshake into a 32-bit word.
// Word, address and write strobe are registered (1-cycle latency); errors halt the encoder until clear_i.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [31:0]       target_i,
  input  logic              clear_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_FULL = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_ORI   = 3'd1;
  localparam logic [2:0] K_ADDI  = 3'd2;
  localparam logic [2:0] K_J     = 3'd3;
  localparam logic [2:0] K_BEQ   = 3'd4;
  localparam logic [2:0] K_LW    = 3'd5;
  localparam logic [2:0] K_SW    = 3'd6;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_KIND = 2'b01;
  localparam logic [1:0] E_BEQ  = 2'b10;
  localparam logic [1:0] E_J    = 2'b11;

  localparam logic [ADDR_W:0] LAST_C = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [31:0] pc, pc4, diff, off;
  logic        off_ok, beq_bad, j_bad, run, accept;
  logic [31:0] word;
  logic [1:0]  enc_err;

  // Branch offset is relative to the delay-slot PC and must fit a signed 16-bit field.
  always_comb begin
    pc      = BASE_ADDR + 32'({count_q, 2'b00});
    pc4     = pc + 32'd4;
    diff    = target_i - pc4;
    off     = $unsigned($signed(diff) >>> 2);
    off_ok  = (off[31:15] == '0) || (off[31:15] == '1);
    beq_bad = (target_i[1:0] != 2'b00) || !off_ok;
    j_bad   = (target_i[1:0] != 2'b00) || (target_i[31:28] != pc4[31:28]);
  end

  always_comb begin
    word    = 32'd0;
    enc_err = E_NONE;
    unique case (kind_i)
      K_RTYPE: word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
      K_ORI:   word = {6'b001101, rs_i, rt_i, imm_i};
      K_ADDI:  word = {6'b001000, rs_i, rt_i, imm_i};
      K_LW:    word = {6'b100011, rs_i, rt_i, imm_i};
      K_SW:    word = {6'b101011, rs_i, rt_i, imm_i};
      K_J: begin
        word = {6'b000010, target_i[27:2]};
        if (j_bad) enc_err = E_J;
      end
      K_BEQ: begin
        word = {6'b000100, rs_i, rt_i, off[15:0]};
        if (beq_bad) enc_err = E_BEQ;
      end
      default: enc_err = E_KIND;
    endcase
  end

  assign run    = (state_q == S_RUN);
  assign accept = valid_i && run;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;
    if (clear_i) begin
      state_d    = S_RUN;
      count_d    = '0;
      err_code_d = E_NONE;
    end else if (accept) begin
      if (enc_err != E_NONE) begin
        state_d    = S_HALT;
        err_code_d = enc_err;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = count_q[ADDR_W-1:0];
        wr_data_d = word;
        count_d   = count_q + 1'b1;
        if (count_q == LAST_C) state_d = S_FULL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_RUN;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_code_q <= E_NONE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_code_q <= err_code_d;
    end
  end

  // ready is held low while reset is asserted even though the state register sits in RUN.
  assign ready_o    = rst_n_i && run;
  assign full_o     = (state_q == S_FULL);
  assign err_o      = (state_q == S_HALT);
  assign err_code_o = err_code_q;
  assign count_o    = count_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases plus a randomized stream against an arithmetic reference model.
module tb_instr_encoder;

  localparam int DEPTH_A = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_clear, b_valid, b_clear;
  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] target;

  logic        a_ready, a_wr_en, a_full, a_err;
  logic [7:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [8:0]  a_count;
  logic [1:0]  a_code;

  logic        b_ready, b_wr_en, b_full, b_err;
  logic [1:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [2:0]  b_count;
  logic [1:0]  b_code;

  int total = 0;
  int bad   = 0;

  // reference model state for instance A
  int          m_cnt;
  bit          m_halt;
  logic [1:0]  m_code;
  bit          x_wr_en;
  int          x_addr;
  logic [31:0] x_data;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(a_valid), .ready_o(a_ready),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct),
    .imm_i(imm), .target_i(target), .clear_i(a_clear),
    .wr_en_o(a_wr_en), .wr_addr_o(a_wr_addr), .wr_data_o(a_wr_data),
    .count_o(a_count), .full_o(a_full), .err_o(a_err), .err_code_o(a_code)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(b_valid), .ready_o(b_ready),
    .kind_i(kind), .rs_i(rs), .rt_i(rt), .rd_i(rd), .funct_i(funct),
    .imm_i(imm), .target_i(target), .clear_i(b_clear),
    .wr_en_o(b_wr_en), .wr_addr_o(b_wr_addr), .wr_data_o(b_wr_data),
    .count_o(b_count), .full_o(b_full), .err_o(b_err), .err_code_o(b_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Encoding from the instruction-set rules, PC taken as 4*cnt (base 0).
  function automatic void model_enc(input logic [2:0] k, input int cnt,
                                    output logic [1:0] ec, output logic [31:0] w);
    logic [31:0] p4;
    int          d, o;
    p4 = 32'(cnt * 4 + 4);
    ec = 2'b00;
    w  = 32'h0;
    case (k)
      3'd0: w = (rs << 21) | (rt << 16) | (rd << 11) | funct;
      3'd1: w = (32'h0D << 26) | (rs << 21) | (rt << 16) | imm;
      3'd2: w = (32'h08 << 26) | (rs << 21) | (rt << 16) | imm;
      3'd5: w = (32'h23 << 26) | (rs << 21) | (rt << 16) | imm;
      3'd6: w = (32'h2B << 26) | (rs << 21) | (rt << 16) | imm;
      3'd3: begin
        w = (32'h02 << 26) | ((target % 32'h1000_0000) / 4);
        if ((target % 4) != 0 || (target / 32'h1000_0000) != (p4 / 32'h1000_0000)) ec = 2'b11;
      end
      3'd4: begin
        d = int'(target - p4);
        o = d / 4;
        w = (32'h04 << 26) | (rs << 21) | (rt << 16) | (o & 32'hFFFF);
        if ((target % 4) != 0 || o < -32768 || o > 32767) ec = 2'b10;
      end
      default: ec = 2'b01;
    endcase
  endfunction

  function automatic bit m_ready();
    return !m_halt && (m_cnt < DEPTH_A);
  endfunction

  task automatic check_a();
    chk("a_ready", a_ready, m_ready());
    chk("a_count", a_count, m_cnt);
    chk("a_full", a_full, m_cnt == DEPTH_A);
    chk("a_err", a_err, m_halt);
    chk("a_code", a_code, m_code);
    chk("a_wr_en", a_wr_en, x_wr_en);
    if (x_wr_en) begin
      chk("a_wr_addr", a_wr_addr, x_addr);
      chk("a_wr_data", a_wr_data, x_data);
    end
  endtask

  // Advance the model on the inputs now applied, then observe after the next rising edge.
  task automatic cycle();
    logic [1:0]  ec;
    logic [31:0] w;
    x_wr_en = 0;
    if (a_clear) begin
      m_cnt = 0; m_halt = 0; m_code = 2'b00;
    end else if (a_valid && m_ready()) begin
      model_enc(kind, m_cnt, ec, w);
      if (ec != 2'b00) begin
        m_halt = 1; m_code = ec;
      end else begin
        x_wr_en = 1; x_addr = m_cnt; x_data = w; m_cnt++;
      end
    end
    @(negedge clk);
    check_a();
  endtask

  task automatic set_ins(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                         input logic [31:0] tg);
    kind = k; rs = s; rt = t; rd = d; funct = f; imm = i; target = tg;
  endtask

  task automatic do_clear();
    a_valid = 0; a_clear = 1; cycle(); a_clear = 0;
  endtask

  initial begin
    rst_n = 0; a_valid = 0; a_clear = 0; b_valid = 0; b_clear = 0;
    set_ins(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0);
    m_cnt = 0; m_halt = 0; m_code = 2'b00; x_wr_en = 0; x_addr = 0; x_data = 0;
    @(negedge clk);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_wr_en", a_wr_en, 1'b0);
    chk("rst_count", a_count, 9'd0);
    chk("rst_err", {a_err, a_code, a_full}, 4'd0);
    @(negedge clk);
    rst_n = 1;
    cycle();
    chk("ready_after_rst", a_ready, 1'b1);

    set_ins(3'd2, 5'd0, 5'd1, 5'd0, 6'd0, 16'd5, 32'd0);
    a_valid = 1; cycle();
    chk("addi_word", a_wr_data, 32'h2001_0005);
    chk("addi_addr", {a_wr_en, a_wr_addr, a_count}, {1'b1, 8'd0, 9'd1});

    do_clear();
    set_ins(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0, 32'd0);
    a_valid = 1; cycle();
    chk("rtype_word", {a_wr_en, a_wr_data}, {1'b1, 32'h0022_1820});
    set_ins(3'd5, 5'd0, 5'd4, 5'd0, 6'd0, 16'h0010, 32'd0);
    cycle();
    chk("lw_word", {a_wr_en, a_wr_data}, {1'b1, 32'h8C04_0010});
    chk("lw_addr", a_wr_addr, 8'd1);

    set_ins(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'd0, 32'h0);
    cycle();
    chk("beq_word", {a_wr_en, a_wr_data}, {1'b1, 32'h1022_FFFD});
    target = 32'h6; cycle();
    chk("beq_bad", {a_wr_en, a_err, a_code, a_ready}, {1'b0, 1'b1, 2'b10, 1'b0});
    set_ins(3'd2, 5'd0, 5'd1, 5'd0, 6'd0, 16'd7, 32'd0);
    cycle();
    chk("halt_ignores", {a_wr_en, a_ready, a_count}, {1'b0, 1'b0, 9'd3});
    do_clear();
    chk("clear_run", {a_ready, a_err, a_code, a_count}, {1'b1, 1'b0, 2'b00, 9'd0});

    set_ins(3'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h40);
    a_valid = 1; cycle();
    chk("j_word", a_wr_data, 32'h0800_0010);
    do_clear();
    set_ins(3'd3, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h1000_0000);
    a_valid = 1; cycle();
    chk("j_region", {a_err, a_code}, {1'b1, 2'b11});
    do_clear();
    kind = 3'd7; a_valid = 1; cycle();
    chk("illegal", {a_err, a_code}, {1'b1, 2'b01});
    do_clear();

    // reset while a write is on the port
    set_ins(3'd1, 5'd3, 5'd4, 5'd0, 6'd0, 16'hBEEF, 32'd0);
    a_valid = 1; cycle();
    a_valid = 1; cycle();
    rst_n = 0; a_valid = 0;
    #1;
    chk("rst_mid_wr_en", a_wr_en, 1'b0);
    chk("rst_mid_count", a_count, 9'd0);
    m_cnt = 0; m_halt = 0; m_code = 2'b00; x_wr_en = 0;
    @(negedge clk);
    rst_n = 1;
    cycle();
    a_valid = 1; cycle();
    chk("after_rst_addr", {a_wr_en, a_wr_addr}, {1'b1, 8'd0});

    for (int n = 0; n < 1500; n++) begin
      int unsigned sel;
      logic [31:0] p4;
      int offs [4];
      offs = '{32767, 32768, -32768, -32769};
      p4 = 32'(m_cnt * 4 + 4);
      a_valid = ($urandom % 10) < 7;
      a_clear = m_halt ? (($urandom % 4) == 0) : (($urandom % 60) == 0);
      sel = $urandom % 32;
      kind = (sel == 31) ? 3'd7 : 3'(sel % 7);
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      funct = 6'($urandom); imm = 16'($urandom);
      sel = $urandom % 8;
      if (kind == 3'd4) begin
        if (sel < 5)       target = p4 + 32'(4 * int'($urandom_range(0, 80)) - 160);
        else if (sel == 5) target = p4 + 32'($urandom_range(1, 3));
        else if (sel == 6) target = p4 + 32'(4 * offs[$urandom % 4]);
        else               target = $urandom;
      end else begin
        if (sel < 6)       target = {p4[31:28], 26'($urandom), 2'b00};
        else if (sel == 6) target = {p4[31:28], 26'($urandom), 2'($urandom_range(1, 3))};
        else               target = $urandom;
      end
      cycle();
    end
    a_valid = 0; a_clear = 0;

    // small instance: fill to capacity, hold valid, then clear
    set_ins(3'd2, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0042, 32'd0);
    b_clear = 1; cycle(); b_clear = 0;
    b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("b_fill_wr", {b_wr_en, b_wr_addr, b_count}, {1'b1, 2'(i), 3'(i + 1)});
      chk("b_fill_word", b_wr_data, 32'h2002_0042);
    end
    chk("b_full", {b_full, b_ready, b_err}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("b_no_wrap", {b_wr_en, b_count, b_full}, {1'b0, 3'd4, 1'b1});
    end
    b_clear = 1; cycle(); b_clear = 0; b_valid = 0;
    chk("b_clear", {b_count, b_ready, b_full, b_wr_en}, {3'd0, 1'b1, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
